shift_cmd_sequencer: RTL and testbench
======================================

# shift_cmd_sequencer

Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its `mode` and `d` inputs. It accepts multi-cycle shift/hold/load commands over a valid/ready handshake and buffers them in a small FIFO. Each command is replayed as an exact number of register clock edges, with a one-cycle completion pulse per command. The outputs connect straight to the register's `mode[1:0]` and `d[3:0]`; both blocks share the same `clk`.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `CNT_W`, 4: width of the repeat count.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the FIFO can accept; equals `!full && !reset`.
- `cmd_op` in 2: 00 hold/wait, 01 shift right, 10 shift left, 11 parallel load.
- `cmd_count` in CNT_W: number of active cycles; ignored for load.
- `cmd_data` in 4: load value; ignored unless op=11.
- `mode` out 2: registered; drives the shift register's `mode`.
- `d` out 4: registered; drives the shift register's `d`.
- `busy` out 1: high when state=EXEC or the FIFO is non-empty.
- `done` out 1: one-cycle pulse on command completion.

## Operation
- **Push:** `cmd_valid && cmd_ready` at an edge writes {op, count, data} into the FIFO. A push is never accepted while full; no overwrite occurs.
- **FSM states:** IDLE and EXEC, plus a remaining-cycle counter `rem` (CNT_W bits).
- **IDLE**, FIFO non-empty before the edge: pop one entry. Then:
  - **Load:** `mode`<=11, `d`<=data, `rem`<=0, go to EXEC. This gives exactly 1 active cycle.
  - **Shift/hold, count N≥1:** `mode`<=op, `rem`<=N-1, go to EXEC. `d` is unchanged.
  - **Shift/hold, count 0:** `mode` stays 00, `done`<=1, stay in IDLE. No register activity.
- **IDLE**, FIFO empty: `mode`=00, `done`<=0.
- **EXEC:**
  - If `rem`==0: `mode`<=00, `done`<=1, go to IDLE.
  - Otherwise: `rem`<=`rem`-1.
- **Result:** `mode` equals the command op for exactly N consecutive cycles, so the shift register sees exactly N active edges. `mode`=00 in the `done` cycle.
- **`d` retention:** `d` holds its last loaded value between loads.
- **Push while empty:** a push in the same cycle the FIFO is empty is not visible to that edge's pop. It is popped at the following edge.
- **Simultaneous push and pop:** allowed when the FIFO is neither full nor empty; occupancy is unchanged. When full, a pop at an edge raises `cmd_ready` only after that edge.
- **Mid-operation reset:** an asserted `reset` at an edge overrides everything.
  - FIFO flushed, state IDLE, `rem`=0.
  - `mode`=00, `d`=0000, `done`=0.
  - In-flight and queued commands are discarded without a `done` pulse.
- **Reset values:** `mode` 00, `d` 0000, `done` 0, `busy` 0. `cmd_ready` is 0 while `reset` is high and 1 in the first cycle after.

## Timing
- **Accept-to-active latency:** for a command accepted at edge E0 into an empty, idle block, `mode` shows the op from E1 to E1+N. `done` is high in the cycle after E1+N.
- **Completion pulse:** `done` is high for exactly one cycle per completed command, including count-0 commands.
- **Back-to-back:** consecutive commands have one hold bubble between them, which is the `done` cycle. Command k+1 becomes active one cycle after command k's `done`.
- **Throughput:** a command with N active cycles occupies N+1 cycles.
- **Worst case:** N=2^CNT_W−1 gives 15 active cycles at the default width.
- **Pipelining:** no combinational path from `cmd_*` to `mode`/`d`.

## Configuration
- **`SHIFT_SEQ_ABORT_EN` defined:** adds an input `abort` (1 bit).
  - When `abort` is high at an edge: flush the FIFO, set `mode`<=00, state<=IDLE, `rem`<=0, and `done`<=0.
  - `d` is retained.
  - A push in that cycle is dropped.
  - `reset` has priority over `abort`.
- **Not defined:** no `abort` port; commands always run to completion.

## Structure
- **Package `shift_seq_pkg`:**
  - Mode encodings MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - FSM state encoding ST_IDLE, ST_EXEC.
  - Command entry width (2+CNT_W+4).
- **Sub-module `shift_cmd_fifo`:** synchronous FIFO with parameters DEPTH and width. It provides `full`/`empty`, push/pop, and same-cycle push+pop support, with synchronous reset to empty.
- **Top:** FSM, `rem` counter, and output registers.

## Test plan
- **Single load:** reset, then push {11, x, 1010} → `mode`=11 and `d`=1010 for one cycle, then `mode`=00 and `done`=1 for one cycle. An attached register reads q=1010.
- **Multi-cycle shift:** push {01, 3, x} after loading 1111 → `mode`=01 for exactly 3 cycles, then q=0001 and one `done`.
- **Back-to-back queue:** push load 0001, SHL×2, SHR×1 consecutively → `cmd_ready` never drops at DEPTH=4. Single bubbles appear between commands, 3 `done` pulses are seen, and final q=0010.
- **Full FIFO:** with the block stalled on {00, 15}, push until `cmd_ready`=0 → exactly DEPTH entries are accepted. The extra valid is held off, with no overwrite and correct order.
- **Count-0 command:** push {10, 0} → `mode` stays 00, `done` pulses once, and q is unchanged.
- **Reset mid-shift:** assert `reset` during a 10-cycle SHR with 2 queued commands → next cycle `mode`=00, `d`=0000, `busy`=0, no `done`, and the queued commands never execute.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-register command sequencer: mode codes
// driven onto the universal shift register, FSM states, and the width of
// one queued command entry.
package shift_seq_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // One queued command is {op, count, data}.
  function automatic int entry_w(input int cnt_w);
    return 2 + cnt_w + 4;
  endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Small synchronous FIFO holding pending commands. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
// Push is ignored when full, pop is ignored when empty; both may occur in
// the same cycle. reset empties the queue on the next edge.
module shift_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset returns the queue to empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer feeding a 4-bit universal shift register. Commands are
// queued and each one is replayed as an exact number of active register
// edges, followed by a single done cycle with mode held at 00.
// Optional feature: define SHIFT_SEQ_ABORT_EN to add an abort input that
// flushes queued and in-flight work while keeping d.
//
// state   | meaning
// IDLE    | no command active; pops the next entry when the queue has one
// EXEC    | command active; rem counts the remaining active cycles
module shift_cmd_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [3:0]       cmd_data,
  output logic [1:0]       mode,
  output logic [3:0]       d,
  output logic             busy,
  output logic             done
);

  localparam int ENTRY_W = entry_w(CNT_W);

  state_t             state;
  logic [CNT_W-1:0]   rem;
  logic               abort_i;
  logic               fifo_clr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [1:0]         head_op;
  logic [CNT_W-1:0]   head_cnt;
  logic [3:0]         head_data;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign fifo_clr  = reset || abort_i;
  assign cmd_ready = !fifo_full && !reset;
  assign push      = cmd_valid && cmd_ready && !abort_i;
  assign pop       = (state == ST_IDLE) && !fifo_empty && !fifo_clr;
  assign busy      = (state == ST_EXEC) || !fifo_empty;

  assign head_op   = head[ENTRY_W-1 -: 2];
  assign head_cnt  = head[4 +: CNT_W];
  assign head_data = head[3:0];

  shift_cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk  (clk),
    .reset(fifo_clr),
    .push (push),
    .pop  (pop),
    .wdata({cmd_op, cmd_count, cmd_data}),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Sequencing FSM with registered mode/d/done; reset beats abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      rem   <= '0;
      mode  <= MODE_HOLD;
      d     <= 4'b0000;
      done  <= 1'b0;
    end else if (abort_i) begin
      state <= ST_IDLE;
      rem   <= '0;
      mode  <= MODE_HOLD;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          mode <= MODE_HOLD;
          done <= 1'b0;
          if (!fifo_empty) begin
            if (head_op == MODE_LOAD) begin
              mode  <= MODE_LOAD;
              d     <= head_data;
              rem   <= '0;
              state <= ST_EXEC;
            end else if (head_cnt != '0) begin
              mode  <= head_op;
              rem   <= head_cnt - CNT_W'(1);
              state <= ST_EXEC;
            end else begin
              // Zero-length command completes without touching the register.
              done <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          done <= 1'b0;
          if (rem == '0) begin
            mode  <= MODE_HOLD;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            rem <= rem - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          mode  <= MODE_HOLD;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer. The reference model expands each queued
// command into its list of per-cycle output slots (N active slots and one
// done slot) and replays them; an attached 4-bit shift register shows q.
module tb_shift_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [3:0]       cmd_data = 4'b0000;
  logic [1:0]       mode;
  logic [3:0]       d;
  logic             busy;
  logic             done;
  logic [3:0]       q_reg;

  int total = 0;
  int bad = 0;

  shift_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort    (1'b0),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_count(cmd_count),
    .cmd_data (cmd_data),
    .mode     (mode),
    .d        (d),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Attached universal shift register, zero fill on shifts.
  always @(posedge clk) begin
    if (reset) q_reg <= 4'b0000;
    else case (mode)
      2'b01:   q_reg <= q_reg >> 1;
      2'b10:   q_reg <= q_reg << 1;
      2'b11:   q_reg <= d;
      default: q_reg <= q_reg;
    endcase
  end

  typedef struct { logic [1:0] m; logic [3:0] dd; bit dn; bit ex; } slot_t;
  typedef struct { logic [1:0] op; int cnt; logic [3:0] data; } cmd_t;

  cmd_t       mq[$];
  slot_t      tr[$];
  slot_t      cur = '{2'b00, 4'b0000, 1'b0, 1'b0};
  logic [3:0] d_last = 4'b0000;

  // Advance the reference model by one edge using the pre-edge inputs.
  task automatic model_edge();
    cmd_t c;
    bit   pushed;
    if (reset) begin
      mq.delete();
      tr.delete();
      d_last = 4'b0000;
      cur = '{2'b00, 4'b0000, 1'b0, 1'b0};
    end else begin
      pushed = cmd_valid && (mq.size() < DEPTH);
      if (tr.size() == 0 && mq.size() > 0) begin
        c = mq.pop_front();
        if (c.op == 2'b11) begin
          d_last = c.data;
          tr.push_back('{2'b11, c.data, 1'b0, 1'b1});
        end else begin
          for (int i = 0; i < c.cnt; i++) tr.push_back('{c.op, d_last, 1'b0, 1'b1});
        end
        tr.push_back('{2'b00, d_last, 1'b1, 1'b0});
      end
      if (pushed) mq.push_back('{cmd_op, int'(cmd_count), cmd_data});
      if (tr.size() > 0) cur = tr.pop_front();
      else cur = '{2'b00, d_last, 1'b0, 1'b0};
    end
  endtask

  function automatic logic [8:0] exp_vec();
    return {cur.m, cur.dd, cur.dn, cur.ex || (mq.size() > 0),
            (mq.size() < DEPTH) && !reset};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {mode, d, done, busy, cmd_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input int cnt, input logic [3:0] data);
    cmd_valid = v;
    cmd_op    = op;
    cmd_count = CNT_W'(cnt);
    cmd_data  = data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 2'b00, 0, 4'h0);
    tick();
    tick();
    total++; if (mode !== 2'b00) begin bad++; $display("FAIL reset_mode got=%b exp=00", mode); end
    total++; if (d !== 4'b0000) begin bad++; $display("FAIL reset_d got=%b exp=0000", d); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_high got=%b exp=0", cmd_ready); end
    reset = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_single_load();
    drive(1, 2'b11, $urandom_range(0, 15), 4'b1010);
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(0, 2'b00, 0, 4'h0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL single_load cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    total++; if (q_reg !== 4'b1010) begin bad++; $display("FAIL single_load_q got=%b exp=1010", q_reg); end
  endtask

  task automatic test_multi_shift();
    int dones = 0;
    drive(1, 2'b11, 0, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) drive(1, 2'b01, 3, $urandom_range(0, 15));
      else drive(0, 2'b00, 0, 4'h0);
      if (done === 1'b1) dones++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL multi_shift cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    total++; if (dones != 2) begin bad++; $display("FAIL multi_shift_dones got=%0d exp=2", dones); end
    total++; if (q_reg !== 4'b0001) begin bad++; $display("FAIL multi_shift_q got=%b exp=0001", q_reg); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    for (int i = 0; i < 3; i++) begin
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready push=%0d got=%b exp=1", i, cmd_ready); end
      case (i)
        0: drive(1, 2'b11, 0, 4'b0001);
        1: drive(1, 2'b10, 2, 4'h0);
        default: drive(1, 2'b01, 1, 4'h0);
      endcase
      tick();
      if (done === 1'b1) dones++;
    end
    drive(0, 2'b00, 0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dones++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    total++; if (dones != 3) begin bad++; $display("FAIL b2b_dones got=%0d exp=3", dones); end
    total++; if (q_reg !== 4'b0010) begin bad++; $display("FAIL b2b_q got=%b exp=0010", q_reg); end
  endtask

  task automatic test_full_fifo();
    int accepted = 0;
    drive(1, 2'b00, 15, 4'h0);
    tick();
    drive(0, 2'b00, 0, 4'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'($urandom_range(0, 3)), $urandom_range(0, 3), 4'($urandom_range(0, 15)));
      if (cmd_ready === 1'b1) accepted++;
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL full_fifo push=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    drive(0, 2'b00, 0, 4'h0);
    total++; if (accepted != DEPTH) begin bad++; $display("FAIL full_fifo_accepted got=%0d exp=%0d", accepted, DEPTH); end
    for (int i = 0; i < 40; i++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL full_fifo_drain cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_count0();
    int dones = 0;
    logic [3:0] q_before;
    q_before = q_reg;
    drive(1, 2'b10, 0, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(0, 2'b00, 0, 4'h0);
      if (done === 1'b1) dones++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL count0 cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    total++; if (dones != 1) begin bad++; $display("FAIL count0_dones got=%0d exp=1", dones); end
    total++; if (q_reg !== q_before) begin bad++; $display("FAIL count0_q got=%b exp=%b", q_reg, q_before); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int active = 0;
    drive(1, 2'b11, 0, 4'b0110);
    tick();
    drive(1, 2'b01, 10, 4'h0);
    tick();
    drive(1, 2'b10, 3, 4'h0);
    tick();
    drive(1, 2'b11, 0, 4'b1001);
    tick();
    drive(0, 2'b00, 0, 4'h0);
    for (int i = 0; i < 5; i++) tick();
    total++; if (mode !== 2'b01) begin bad++; $display("FAIL reset_mid_pre_mode got=%b exp=01", mode); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (mode !== 2'b00) begin bad++; $display("FAIL reset_mid_mode got=%b exp=00", mode); end
    total++; if (d !== 4'b0000) begin bad++; $display("FAIL reset_mid_d got=%b exp=0000", d); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_mid_done got=%b exp=0", done); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) dones++;
      if (mode !== 2'b00) active++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    total++; if (dones != 0 || active != 0) begin
      bad++; $display("FAIL reset_mid_discard dones=%0d active=%0d exp=0/0", dones, active);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 5),
            4'($urandom_range(0, 15)));
      reset = ($urandom_range(0, 99) == 0);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    reset = 1'b0;
    drive(0, 2'b00, 0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_multi_shift();
    test_back_to_back();
    test_full_fifo();
    test_count0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
